// File: rtl/multicycle_controller.sv
// Main control FSM and ALU decoder for the multicycle MIPS datapath.
// Moore outputs decode from state; mem_ready, zero, op and funct gate the handshake, branch and illegal paths.
//   FETCH   | read instruction at PC, PC += 4
//   DECODE  | register read, branch target into ALUOut
//   MEMADR  | effective address for lw/sw
//   MEMRD   | load data read, waits for mem_ready
//   MEMWB   | load data to rt, retire
//   MEMWR   | store strobe held until mem_ready, retire
//   RTYPEEX | R-type ALU operation
//   RTYPEWB | ALU result to rd, retire
//   BEQEX   | compare, conditional PC load, retire
//   ADDIEX  | immediate add
//   ADDIWB  | ALU result to rt, retire
//   JEX     | jump target to PC, retire
module multicycle_controller #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             iord,
    output logic             irwrite,
    output logic             memwrite,
    output logic             regwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic [2:0]       alucontrol,
    output logic             pcen,
    output logic             illegal,
    output logic             retire,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RTYPEEX, S_RTYPEWB, S_BEQEX, S_ADDIEX, S_ADDIWB, S_JEX
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q;
    logic               rdy;
    logic [1:0]         aluop;
    logic               funct_ok;
    logic               irw_d, memw_d, regw_d, pcwrite_d, branch_d, illegal_d, retire_d;

    assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

    always_comb begin
        state_d   = state_q;
        iord      = 1'b0;
        irw_d     = 1'b0;
        memw_d    = 1'b0;
        regw_d    = 1'b0;
        regdst    = 1'b0;
        memtoreg  = 1'b0;
        alusrca   = 1'b0;
        alusrcb   = 2'b00;
        pcsrc     = 2'b00;
        aluop     = 2'b00;
        pcwrite_d = 1'b0;
        branch_d  = 1'b0;
        illegal_d = 1'b0;
        retire_d  = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb   = 2'b01;
                irw_d     = rdy;
                pcwrite_d = rdy;
                if (rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYP:      state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regw_d   = 1'b1;
                retire_d = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                iord   = 1'b1;
                memw_d = 1'b1;
                if (rdy) begin
                    retire_d = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                if (funct_ok) begin
                    state_d = S_RTYPEWB;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regw_d   = 1'b1;
                retire_d = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQEX: begin
                alusrca  = 1'b1;
                aluop    = 2'b01;
                pcsrc    = 2'b01;
                branch_d = 1'b1;
                retire_d = 1'b1;
                state_d  = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regw_d   = 1'b1;
                retire_d = 1'b1;
                state_d  = S_FETCH;
            end
            S_JEX: begin
                pcsrc     = 2'b10;
                pcwrite_d = 1'b1;
                retire_d  = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // funct legality is decoded independently of aluop so the FSM can consult it without a loop
    always_comb begin
        funct_ok   = 1'b1;
        alucontrol = 3'b010;
        case (funct)
            6'b100000: alucontrol = 3'b010;
            6'b100010: alucontrol = 3'b110;
            6'b100100: alucontrol = 3'b000;
            6'b100101: alucontrol = 3'b001;
            6'b101010: alucontrol = 3'b111;
            default:   funct_ok   = 1'b0;
        endcase
        if (aluop == 2'b00)      alucontrol = 3'b010;
        else if (aluop == 2'b01) alucontrol = 3'b110;
        else if (aluop == 2'b11) alucontrol = 3'b010;
    end

    // Strobes are gated by reset so they drop the instant reset falls, not at the next edge.
    assign irwrite     = reset & irw_d;
    assign memwrite    = reset & memw_d;
    assign regwrite    = reset & regw_d;
    assign illegal     = reset & illegal_d;
    assign retire      = reset & retire_d;
    assign pcen        = reset & (pcwrite_d | (branch_d & zero));
    assign instr_count = count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction vector table with a scoreboard,
// plus hand sequences for reset, mid-store reset and counter wrap (counter narrowed to 4 bits).
module tb_multicycle_controller;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [5:0]    op = 6'b0, funct = 6'b0;
    logic          zero = 1'b0, mem_ready = 1'b1;
    logic          iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca, pcen, illegal, retire;
    logic [1:0]    alusrcb, pcsrc;
    logic [2:0]    alucontrol;
    logic [CW-1:0] instr_count;

    multicycle_controller #(.MEM_HANDSHAKE(1'b1), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .iord(iord), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
        .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .alucontrol(alucontrol), .pcen(pcen), .illegal(illegal),
        .retire(retire), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         fst, mst, cyc;
        int         n_irw, n_ret, n_ill, n_regw, n_memw, n_pcen;
        logic       chk_alu;
        logic [2:0] alu;
        logic [1:0] pcsrc;
        logic [1:0] wb;
    } vec_t;

    vec_t          tbl[15];
    vec_t          sb[$];
    vec_t          jv;
    int            n_cmp = 0, n_bad = 0;
    logic [CW-1:0] exp_cnt = '0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic run_vec(input int id, input vec_t v);
        vec_t       e;
        int         c_irw = 0, c_ret = 0, c_ill = 0, c_regw = 0, c_memw = 0, c_pcen = 0, c_badio = 0;
        logic [2:0] alu_s = 3'b0;
        logic [1:0] pcs_s = 2'b0, wb_s = 2'b0;
        bit         is_mem;
        sb.push_back(v);
        op = v.op; funct = v.funct; zero = v.zero;
        is_mem = (v.op == 6'b100011) || (v.op == 6'b101011);
        for (int idx = 0; idx < v.cyc; idx++) begin
            mem_ready = !((idx < v.fst) ||
                          (is_mem && idx >= v.fst + 3 && idx < v.fst + 3 + v.mst));
            @(negedge clk);
            if (idx == v.fst) chk($sformatf("v%0d_fetch_entry", id), 32'(irwrite), 32'd1);
            c_irw  += int'(irwrite);
            c_ret  += int'(retire);
            c_ill  += int'(illegal);
            c_regw += int'(regwrite);
            c_memw += int'(memwrite);
            c_pcen += int'(pcen);
            if (memwrite && !iord) c_badio++;
            if (regwrite) wb_s = {regdst, memtoreg};
            if (idx == v.fst + 2) begin
                alu_s = alucontrol;
                pcs_s = pcsrc;
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        e = sb.pop_front();
        chk($sformatf("v%0d_irwrite_cycles", id), 32'(c_irw), 32'(e.n_irw));
        chk($sformatf("v%0d_retire_pulses", id), 32'(c_ret), 32'(e.n_ret));
        chk($sformatf("v%0d_illegal_pulses", id), 32'(c_ill), 32'(e.n_ill));
        chk($sformatf("v%0d_regwrite_cycles", id), 32'(c_regw), 32'(e.n_regw));
        chk($sformatf("v%0d_memwrite_cycles", id), 32'(c_memw), 32'(e.n_memw));
        chk($sformatf("v%0d_pcen_cycles", id), 32'(c_pcen), 32'(e.n_pcen));
        if (e.n_memw > 0) chk($sformatf("v%0d_memwrite_without_iord", id), 32'(c_badio), 32'd0);
        if (e.chk_alu) begin
            chk($sformatf("v%0d_exec_alucontrol", id), 32'(alu_s), 32'(e.alu));
            chk($sformatf("v%0d_exec_pcsrc", id), 32'(pcs_s), 32'(e.pcsrc));
        end
        if (e.n_regw > 0) chk($sformatf("v%0d_wb_regdst_memtoreg", id), 32'(wb_s), 32'(e.wb));
        exp_cnt = exp_cnt + CW'(e.n_ret);
        chk($sformatf("v%0d_instr_count", id), 32'(instr_count), 32'(exp_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        //            op         funct      z     fst mst cyc irw ret ill rgw mmw pce chk   alu     pcsrc  wb
        tbl[0]  = '{6'b100011, 6'b000000, 1'b0, 0, 0, 5, 1, 1, 0, 1, 0, 1, 1'b1, 3'b010, 2'b00, 2'b01};
        tbl[1]  = '{6'b100011, 6'b000000, 1'b0, 1, 2, 8, 1, 1, 0, 1, 0, 1, 1'b1, 3'b010, 2'b00, 2'b01};
        tbl[2]  = '{6'b101011, 6'b000000, 1'b0, 0, 2, 6, 1, 1, 0, 0, 3, 1, 1'b1, 3'b010, 2'b00, 2'b00};
        tbl[3]  = '{6'b101011, 6'b000000, 1'b0, 0, 0, 4, 1, 1, 0, 0, 1, 1, 1'b1, 3'b010, 2'b00, 2'b00};
        tbl[4]  = '{6'b000000, 6'b100000, 1'b0, 0, 0, 4, 1, 1, 0, 1, 0, 1, 1'b1, 3'b010, 2'b00, 2'b10};
        tbl[5]  = '{6'b000000, 6'b100010, 1'b0, 0, 0, 4, 1, 1, 0, 1, 0, 1, 1'b1, 3'b110, 2'b00, 2'b10};
        tbl[6]  = '{6'b000000, 6'b100100, 1'b0, 0, 0, 4, 1, 1, 0, 1, 0, 1, 1'b1, 3'b000, 2'b00, 2'b10};
        tbl[7]  = '{6'b000000, 6'b100101, 1'b0, 0, 0, 4, 1, 1, 0, 1, 0, 1, 1'b1, 3'b001, 2'b00, 2'b10};
        tbl[8]  = '{6'b000000, 6'b101010, 1'b0, 0, 0, 4, 1, 1, 0, 1, 0, 1, 1'b1, 3'b111, 2'b00, 2'b10};
        tbl[9]  = '{6'b000000, 6'b000111, 1'b0, 0, 0, 3, 1, 0, 1, 0, 0, 1, 1'b1, 3'b010, 2'b00, 2'b00};
        tbl[10] = '{6'b000100, 6'b000000, 1'b1, 0, 0, 3, 1, 1, 0, 0, 0, 2, 1'b1, 3'b110, 2'b01, 2'b00};
        tbl[11] = '{6'b000100, 6'b000000, 1'b0, 0, 0, 3, 1, 1, 0, 0, 0, 1, 1'b1, 3'b110, 2'b01, 2'b00};
        tbl[12] = '{6'b001000, 6'b000000, 1'b0, 0, 0, 4, 1, 1, 0, 1, 0, 1, 1'b1, 3'b010, 2'b00, 2'b00};
        tbl[13] = '{6'b000010, 6'b000000, 1'b0, 0, 0, 3, 1, 1, 0, 0, 0, 2, 1'b1, 3'b010, 2'b10, 2'b00};
        tbl[14] = '{6'b111111, 6'b000000, 1'b0, 0, 0, 2, 1, 0, 1, 0, 0, 1, 1'b0, 3'b010, 2'b00, 2'b00};
        jv = tbl[13];

        // Reset held with mem_ready high: FETCH strobes must stay off.
        #2;
        chk("rst_irwrite", 32'(irwrite), 32'd0);
        chk("rst_pcen", 32'(pcen), 32'd0);
        chk("rst_retire_illegal", 32'({retire, illegal}), 32'd0);
        chk("rst_count", 32'(instr_count), 32'd0);
        @(posedge clk); #1 reset = 1'b1;

        // lw after reset release, cycle by cycle.
        op = 6'b100011; funct = 6'b0; mem_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            case (c)
                0: chk("lw_c1_fetch", 32'({irwrite, iord, alusrca, alusrcb, pcen}), 32'b1_0_0_01_1);
                1: chk("lw_c2_decode", 32'({irwrite, alusrca, alusrcb}), 32'b0_0_11);
                2: chk("lw_c3_memadr", 32'({alusrca, alusrcb, iord}), 32'b1_10_0);
                3: chk("lw_c4_memrd", 32'({iord, memwrite, regwrite}), 32'b1_0_0);
                default: chk("lw_c5_memwb", 32'({regwrite, memtoreg, regdst, retire}), 32'b1_1_0_1);
            endcase
            @(posedge clk); #1;
        end
        exp_cnt = exp_cnt + CW'(1);
        chk("lw_count", 32'(instr_count), 32'(exp_cnt));

        for (int i = 0; i < 15; i++) run_vec(i, tbl[i]);

        // Reset dropped while a store is waiting in MEMWR.
        op = 6'b101011; mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        mem_ready = 1'b0;
        @(negedge clk);
        chk("midrst_pre_memwrite", 32'({memwrite, iord}), 32'b11);
        #1 reset = 1'b0;
        #1;
        chk("midrst_memwrite_drop", 32'(memwrite), 32'd0);
        chk("midrst_no_retire", 32'({regwrite, retire}), 32'd0);
        chk("midrst_count_clear", 32'(instr_count), 32'd0);
        exp_cnt = '0;
        @(posedge clk); #1 reset = 1'b1; mem_ready = 1'b1; op = 6'b000010;
        @(negedge clk);
        chk("midrst_fetch_after", 32'(irwrite), 32'd1);
        chk("midrst_count_after", 32'(instr_count), 32'd0);
        mem_ready = 1'b0;
        @(posedge clk); #1;

        // Counter wrap: 15 jumps reach all-ones, one more wraps to zero.
        for (int i = 0; i < 15; i++) run_vec(100 + i, jv);
        chk("count_allones", 32'(instr_count), 32'hF);
        run_vec(200, jv);
        chk("count_wrap", 32'(instr_count), 32'd0);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
